// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding and
// default reset/increment values.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_INCR  = 1;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries; registered head, no bypass.
// Flush empties the buffer and overrides push/pop on the same edge.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC generator, single-outstanding imem request
// FSM and prefetch buffer feeding decode over valid/ready.
//   state  | meaning
//   IDLE   | nothing outstanding
//   REQ    | request outstanding, response is kept
//   DROP   | request outstanding, response is discarded (after redirect/halt)
//   HALTED | stopped until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_INCR  = DEF_PC_INCR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               hlt,
  output logic [ADDR_W-1:0]  pc
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INCR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              hlt_q, hlt_d;

  logic              ack, halt_go, redir_go, flush, push, pop, issue, issue_fire;
  logic [CNT_W-1:0]  count, next_count;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  head;

  // Halt beats redirect; both are ignored once halted.
  assign halt_go    = halt_req & ~hlt_q;
  assign redir_go   = redirect_valid & ~halt_req & ~hlt_q;
  assign flush      = halt_go | redir_go;
  assign ack        = imem_ack & imem_req;
  assign pop        = instr_valid & instr_ready & ~flush;
  assign push       = ack & (state_q == ST_REQ) & ~flush & (~fifo_full | pop);
  assign next_count = count + CNT_W'(push) - CNT_W'(pop);
  assign issue      = (next_count < DEPTH_C) & ~flush & ~hlt_q;

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({req_addr_q, imem_rdata}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= PC_RST;
      req_addr_q <= '0;
      hlt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      hlt_q      <= hlt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (halt_go) begin
          state_d = ST_HALTED;
        end else if (issue) begin
          state_d    = ST_REQ;
          issue_fire = 1'b1;
        end
      end
      ST_REQ: begin
        if (halt_go) begin
          state_d = ack ? ST_HALTED : ST_DROP;
        end else if (redir_go) begin
          state_d = ack ? ST_IDLE : ST_DROP;
        end else if (ack) begin
          if (issue) issue_fire = 1'b1;
          else       state_d    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (ack) begin
          if (hlt_q || halt_go) begin
            state_d = ST_HALTED;
          end else if (issue) begin
            state_d    = ST_REQ;
            issue_fire = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
    hlt_d      = hlt_q | halt_go;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (redir_go) begin
      fetch_pc_d = redirect_pc;
    end else if (issue_fire) begin
      req_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  assign imem_addr         = req_addr_q;
  assign instr_valid       = ~fifo_empty;
  assign {instr_pc, instr} = head;
  assign hlt               = hlt_q;
  assign pc                = fetch_pc_q;

endmodule
